// File: rtl/fib_seq_ctrl_pkg.sv
// rtl/fib_seq_ctrl_pkg.sv - shared FSM state encoding and default parameters for fib_seq_ctrl
package fib_seq_ctrl_pkg;

  localparam int DEF_DATA_WIDTH  = 15;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RST_CYCLES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRST,
    ST_ARM,
    ST_WAIT,
    ST_HOLD,
    ST_ACK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/click_req_sync.sv
// rtl/click_req_sync.sv - multi-flop synchronizer for the pipeline's 2-phase request
module click_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  output logic o_req
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw request through the chain; only the last stage is trusted downstream
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_req};
    end
  end

  assign o_req = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fib_seq_ctrl.sv
// rtl/fib_seq_ctrl.sv - click-pipeline run controller with term stream; FIB_SEQ_CTRL_OVF_EN adds wrap detection
module fib_seq_ctrl
  import fib_seq_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [7:0]          i_num_terms,
  output logic                o_fib_rst,
  output logic                o_go,
  input  logic                i_fib_req,
  input  logic [DATA_WIDTH:0] i_fib_data,
  output logic                o_fib_ack,
  output logic                o_term_valid,
  input  logic                i_term_ready,
  output logic [DATA_WIDTH:0] o_term_data,
  output logic [7:0]          o_term_idx,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_e              state_q;
  logic                fib_rst_q, go_q, ack_q, valid_q, done_q;
  logic [DATA_WIDTH:0] data_q;
  logic [7:0]          idx_q, count_q, n_q;
  logic [RCW-1:0]      rst_cnt_q;
  logic                req_sync;
  logic                stop;

  click_req_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_fib_req),
    .o_req   (req_sync)
  );

  // Run sequencer: pipeline reset, arm, then one handshake + stream transfer per term
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      fib_rst_q <= 1'b1;
      go_q      <= 1'b0;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
      n_q       <= '0;
      rst_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          fib_rst_q <= 1'b1;
          go_q      <= 1'b0;
          if (i_start) begin
            n_q       <= i_num_terms;
            count_q   <= '0;
            rst_cnt_q <= '0;
            state_q   <= (i_num_terms == 8'd0) ? ST_DONE : ST_PRST;
          end
        end
        ST_PRST: begin
          // The pipeline restarts its own phase at 0, so ours must match
          ack_q <= 1'b0;
          if (rst_cnt_q == RST_LAST) begin
            fib_rst_q <= 1'b0;
            go_q      <= 1'b1;
            state_q   <= ST_ARM;
          end else begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
        end
        ST_ARM: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (req_sync != ack_q) begin
            data_q  <= i_fib_data;
            idx_q   <= count_q;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_term_ready) begin
            valid_q <= 1'b0;
            count_q <= count_q + 8'd1;
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          ack_q <= ~ack_q;
          if ((count_q == n_q) || stop) begin
            go_q    <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_DONE: begin
          done_q    <= 1'b1;
          fib_rst_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FIB_SEQ_CTRL_OVF_EN
  logic [DATA_WIDTH:0] prev_q;
  logic                ovf_q;

  // A term smaller than its predecessor means the pipeline adder wrapped; stop after it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else if ((state_q == ST_IDLE) && i_start) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else if (state_q == ST_HOLD) begin
      if (data_q < prev_q) begin
        ovf_q <= 1'b1;
      end
      if (i_term_ready) begin
        prev_q <= data_q;
      end
    end
  end

  assign stop       = ovf_q;
  assign o_overflow = ovf_q;
`else
  assign stop       = 1'b0;
  assign o_overflow = 1'b0;
`endif

  assign o_fib_rst    = fib_rst_q;
  assign o_go         = go_q;
  assign o_fib_ack    = ack_q;
  assign o_term_valid = valid_q;
  assign o_term_data  = data_q;
  assign o_term_idx   = idx_q;
  assign o_done       = done_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb/tb_fib_seq_ctrl.sv - randomized self-checking bench for fib_seq_ctrl
`timescale 1ns/1ps
module tb_fib_seq_ctrl;

`ifdef FIB_SEQ_CTRL_OVF_EN
  localparam int DW = 3;
`else
  localparam int DW = 15;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    num_terms = 8'd0;
  logic          fib_req = 1'b0;
  logic [DW:0]   fib_data = '0;
  logic          term_ready = 1'b1;
  logic          o_fib_rst, o_go, o_fib_ack, o_term_valid, o_busy, o_done, o_overflow;
  logic [DW:0]   o_term_data;
  logic [7:0]    o_term_idx;

  int checks = 0;
  int errors = 0;

  // Pipeline model and scoreboard state
  logic [DW:0]   sent[$];
  logic [DW:0]   fa, fb, fn;
  int            dly = 0;
  int            acc_cnt = 0, ack_tog = 0, done_cnt = 0, go_seen = 0;
  int            stall_pct = 0, stall_idx = -1, force_stall = 0, stall_ack_ref = 0;
  logic          prev_ack = 1'b0, prev_go = 1'b0;

  fib_seq_ctrl #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2),
    .RST_CYCLES  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_num_terms  (num_terms),
    .o_fib_rst    (o_fib_rst),
    .o_go         (o_go),
    .i_fib_req    (fib_req),
    .i_fib_data   (fib_data),
    .o_fib_ack    (o_fib_ack),
    .o_term_valid (o_term_valid),
    .i_term_ready (term_ready),
    .o_term_data  (o_term_data),
    .o_term_idx   (o_term_idx),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected number of accepted terms for a run of n, and whether it ends by wrap
  function automatic int exp_terms(input int n, output bit ovf);
    logic [DW:0] a, b, c, prev;
    a = 1; b = 1; prev = '0; ovf = 1'b0;
    for (int k = 0; k < n; k++) begin
`ifdef FIB_SEQ_CTRL_OVF_EN
      if (a < prev) begin
        ovf = 1'b1;
        return k + 1;
      end
`endif
      prev = a;
      c = a + b;
      a = b;
      b = c;
    end
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fib_rst"}, o_fib_rst, 1);
    check({tag, "_go"}, o_go, 0);
    check({tag, "_ack"}, o_fib_ack, 0);
    check({tag, "_valid"}, o_term_valid, 0);
    check({tag, "_data"}, o_term_data, 0);
    check({tag, "_idx"}, o_term_idx, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_ovf"}, o_overflow, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  // Click-pipeline responder, ready driver and stream scoreboard, all on the falling edge
  initial begin
    fa = 1; fb = 1;
    forever begin
      @(negedge clk);
      if (prev_go && (o_fib_ack !== prev_ack)) ack_tog++;
      prev_ack = o_fib_ack;
      prev_go  = o_go;
      if (o_done) done_cnt++;
      if (o_go) go_seen++;

      if (o_fib_rst) begin
        fib_req = 1'b0; fa = 1; fb = 1; dly = 0;
        sent.delete();
      end else if (o_go && (fib_req == o_fib_ack)) begin
        if (dly == 0) begin
          fib_data = fa;
          sent.push_back(fa);
          fn = fa + fb; fa = fb; fb = fn;
          fib_req = ~fib_req;
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end

      if (o_term_valid && (acc_cnt == stall_idx)) begin
        force_stall = 10; stall_idx = -1; stall_ack_ref = ack_tog;
      end
      if (force_stall > 0) begin
        term_ready = 1'b0;
        force_stall--;
        check("stall_ack", ack_tog, stall_ack_ref);
        check("stall_valid", o_term_valid, 1);
      end else begin
        term_ready = ($urandom_range(0, 99) >= stall_pct);
      end

      if (o_term_valid) begin
        if (sent.size() == 0) begin
          check("term_orphan", 0, 1);
        end else begin
          check("term_data", o_term_data, sent[0]);
          check("term_idx", o_term_idx, acc_cnt);
          if (term_ready) begin
            void'(sent.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  task automatic do_run(input string name, input int n, input int pct, input int stall_at, input bit poke);
    int exp_n;
    bit exp_ovf;
    bit seen;
    exp_n = exp_terms(n, exp_ovf);
    @(posedge clk); #2;
    acc_cnt = 0; ack_tog = 0; done_cnt = 0; go_seen = 0;
    stall_pct = pct; stall_idx = stall_at;
    start = 1'b1; num_terms = n[7:0];
    @(posedge clk); #2;
    start = 1'b0; num_terms = 8'($urandom);
    if (poke) begin
      seen = 1'b0;
      for (int c = 0; c < 500 && !seen; c++) begin
        @(posedge clk); #2;
        seen = o_go && !o_term_valid;
      end
      check({name, "_poke_reach"}, seen, 1);
      start = 1'b1; num_terms = 8'(n + 7);
      @(posedge clk); #2;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #2;
      seen = (done_cnt > 0);
    end
    check({name, "_done_seen"}, seen, 1);
    repeat (4) @(posedge clk);
    #2;
    check({name, "_terms"}, acc_cnt, exp_n);
    check({name, "_acks"}, ack_tog, exp_n);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_go_low"}, o_go, 0);
    check({name, "_busy_low"}, o_busy, 0);
    check({name, "_go_seen"}, (go_seen > 0), 1);
    check({name, "_ovf"}, o_overflow, exp_ovf);
  endtask

  initial begin
    logic ack_before;
    bit   seen;
    #13;
    check_reset_outputs("por");
    @(posedge clk); #2;
    rst_n = 1'b1;

    do_run("basic5", 5, 0, -1, 1'b0);

    // Zero-length run: done after two edges, pipeline untouched
    @(posedge clk); #2;
    ack_before = o_fib_ack; go_seen = 0; done_cnt = 0;
    start = 1'b1; num_terms = 8'd0;
    @(posedge clk); #2;
    start = 1'b0;
    check("zero_done_early", o_done, 0);
    @(posedge clk); #2;
    check("zero_done", o_done, 1);
    repeat (3) @(posedge clk);
    #2;
    check("zero_done_cnt", done_cnt, 1);
    check("zero_go", go_seen, 0);
    check("zero_ack", o_fib_ack, ack_before);

    do_run("stall3", 3, 0, 1, 1'b0);
    do_run("poke4", 4, 30, -1, 1'b1);

    // Reset in the middle of a 6-term run
    @(posedge clk); #2;
    acc_cnt = 0; done_cnt = 0; stall_pct = 20; stall_idx = -1;
    start = 1'b1; num_terms = 8'd6;
    @(posedge clk); #2;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk); #2;
      seen = (acc_cnt == 2);
    end
    check("midrst_reach", seen, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("midrst_no_done", done_cnt, 0);
    do_run("rerun2", 2, 20, -1, 1'b0);

`ifdef FIB_SEQ_CTRL_OVF_EN
    do_run("ovf10", 10, 10, -1, 1'b0);
`endif

    for (int r = 0; r < 6; r++) begin
      do_run($sformatf("rand%0d", r), $urandom_range(1, 12), $urandom_range(0, 60),
             -1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
